// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   DefWidth / DefStages : default operand width and slice count
//   MaxWidth             : widest operand the stage bundle can carry
//   stage_t              : one pipeline stage register bundle
package pipelined_addsub_pkg;

    localparam int unsigned DefWidth  = 16;
    localparam int unsigned DefStages = 4;
    localparam int unsigned MaxWidth  = 64;

    // Fields are sized for MaxWidth; only the low WIDTH bits carry data.
    typedef struct packed {
        logic                valid;
        logic                carry;  // carry out of the slice just processed
        logic                cmsb;   // carry into the MSB of that slice
        logic [MaxWidth-1:0] sum;    // completed sum bits so far
        logic [MaxWidth-1:0] x_rem;  // operand x, upper slices still pending
        logic [MaxWidth-1:0] y_rem;  // operand yy (y or ~y), upper slices still pending
    } stage_t;

endpackage

// File: rtl/pipelined_addsub_rca_slice.sv
// Combinational SW-bit ripple-carry slice built from per-bit full adders.
//   a, b     : slice operands
//   ci       : carry into bit 0
//   s        : slice sum
//   co       : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (signed-overflow detection)
module rca_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    logic [SW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(SW); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   x, y, cin, sub      : operands, carry/borrow in, subtract select
//   out_valid/out_ready : result handshake
//   s, cout, ovf, zero  : result, carry (inverted borrow when sub), signed overflow, zero
// Each stage ripples one SW-bit slice and registers it; a single global stall
// freezes every stage while the output holds an unaccepted result.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STAGES = DefStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SW = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0 || WIDTH > MaxWidth) begin : gen_param_err
        $error("pipelined_addsub: illegal WIDTH/STAGES combination");
    end

    stage_t           stage_q [STAGES];
    stage_t           stage_d [STAGES];
    stage_t           last;
    logic [WIDTH-1:0] yy;
    logic             c0;
    logic             stall;
    logic             accept;

    // Subtract is x + ~y + 1 - cin, so the bit-0 carry becomes cin ^ sub.
    assign yy     = sub ? ~y : y;
    assign c0     = cin ^ sub;
    assign last   = stage_q[STAGES-1];
    assign stall  = last.valid && !out_ready;
    assign accept = in_valid && !stall;

    for (genvar k = 0; k < int'(STAGES); k++) begin : gen_stage
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic          ci;
        logic [SW-1:0] sum;
        logic          co;
        logic          cmsb;
        stage_t        d;

        if (k == 0) begin : gen_first
            assign a  = x[SW-1:0];
            assign b  = yy[SW-1:0];
            assign ci = c0;

            // A cycle with no accept loads a bubble (valid = 0).
            always_comb begin
                d       = '0;
                d.valid = accept;
                d.carry = co;
                d.cmsb  = cmsb;
                d.sum   = MaxWidth'(sum);
                d.x_rem = MaxWidth'(x);
                d.y_rem = MaxWidth'(yy);
            end
        end else begin : gen_rest
            assign a  = stage_q[k-1].x_rem[k*SW +: SW];
            assign b  = stage_q[k-1].y_rem[k*SW +: SW];
            assign ci = stage_q[k-1].carry;

            always_comb begin
                d                  = stage_q[k-1];
                d.carry            = co;
                d.cmsb             = cmsb;
                d.sum[k*SW +: SW]  = sum;
            end
        end

        rca_slice #(
            .SW(SW)
        ) u_slice (
            .a       (a),
            .b       (b),
            .ci      (ci),
            .s       (sum),
            .co      (co),
            .c_msb_in(cmsb)
        );

        assign stage_d[k] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign in_ready  = !stall;
    assign out_valid = last.valid;
    assign s         = last.sum[WIDTH-1:0];
    assign cout      = last.carry;
    assign ovf       = last.carry ^ last.cmsb;
    // Gated by valid so the flag reads 0 out of reset rather than "sum is 0".
    assign zero      = last.valid & ~|last.sum[WIDTH-1:0];

    // Operand copies and bits above WIDTH are dead once the last slice is done.
    logic unused_last;
    assign unused_last = ^{last.x_rem, last.y_rem, last.sum};

endmodule
